// File: rtl/clock_pkg.sv
// Shared state encodings and default cycle counts for the watch button front end.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    typedef enum logic [1:0] {
        M_IDLE      = 2'd0,
        M_HELD      = 2'd1,
        M_LONG_DONE = 2'd2
    } mode_state_t;

    localparam int unsigned DEF_LONG_PRESS_CYC = 32'd200_000_000;
    localparam int unsigned DEF_HOLD_DELAY_CYC = 32'd50_000_000;
    localparam int unsigned DEF_REPEAT_CYC     = 32'd10_000_000;

    // Terminal counter value for a phase lasting n cycles.
    function automatic logic [31:0] last_cnt(input int unsigned n);
        return 32'(n - 32'd1);
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Press pulse plus auto-repeat for one add/sub button; suppress_i kills the pulse
// issued from the current sample without disturbing the FSM.
module key_repeat
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_DELAY_CYC = DEF_HOLD_DELAY_CYC,
    parameter int unsigned REPEAT_CYC     = DEF_REPEAT_CYC
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    input  logic suppress_i,
    output logic pulse_o
);

    localparam logic [31:0] HOLD_LAST   = last_cnt(HOLD_DELAY_CYC);
    localparam logic [31:0] REPEAT_LAST = last_cnt(REPEAT_CYC);

    rep_state_t  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        prev_q, prev_d;
    logic        pulse_q, pulse_d;
    logic        fire_s;

    // Next-state, counter and pulse decode; release takes priority over terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_s  = 1'b0;
        prev_d  = btn_i;
        case (state_q)
            IDLE: begin
                cnt_d = 32'd0;
                if (btn_i && !prev_q) begin
                    fire_s  = 1'b1;
                    state_d = DELAY;
                end else begin
                    state_d = IDLE;
                end
            end
            DELAY: begin
                if (!btn_i) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                end else if (cnt_q == HOLD_LAST) begin
                    fire_s  = 1'b1;
                    state_d = REPEAT;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            REPEAT: begin
                if (!btn_i) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                end else if (cnt_q == REPEAT_LAST) begin
                    fire_s = 1'b1;
                    cnt_d  = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 32'd0;
            end
        endcase
        pulse_d = fire_s & ~suppress_i;
    end

    // State registers; previous level resets high so a held key is ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/button_events.sv
// Turns debounced mode/add/sub levels into single-cycle watch commands:
// mode short/long classification, add/sub press with auto-repeat and conflict masking.
module button_events
    import clock_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYC = DEF_LONG_PRESS_CYC,
    parameter int unsigned HOLD_DELAY_CYC = DEF_HOLD_DELAY_CYC,
    parameter int unsigned REPEAT_CYC     = DEF_REPEAT_CYC
) (
    input  logic clock,
    input  logic reset,
    input  logic mode_i,
    input  logic add_i,
    input  logic sub_i,
    output logic mode_short_o,
    output logic mode_long_o,
    output logic add_pulse_o,
    output logic sub_pulse_o
);

    localparam logic [31:0] LONG_LAST = last_cnt(LONG_PRESS_CYC);

    logic conflict_s;
    assign conflict_s = add_i & sub_i;

    key_repeat #(.HOLD_DELAY_CYC(HOLD_DELAY_CYC), .REPEAT_CYC(REPEAT_CYC)) u_add (
        .clock      (clock),
        .reset      (reset),
        .btn_i      (add_i),
        .suppress_i (conflict_s),
        .pulse_o    (add_pulse_o)
    );

    key_repeat #(.HOLD_DELAY_CYC(HOLD_DELAY_CYC), .REPEAT_CYC(REPEAT_CYC)) u_sub (
        .clock      (clock),
        .reset      (reset),
        .btn_i      (sub_i),
        .suppress_i (conflict_s),
        .pulse_o    (sub_pulse_o)
    );

    mode_state_t m_state_q, m_state_d;
    logic [31:0] m_cnt_q, m_cnt_d;
    logic        m_prev_q, m_prev_d;
    logic        short_q, short_d;
    logic        long_q, long_d;

    // Mode classifier: any release before the long pulse counts as short.
    always_comb begin
        m_state_d = m_state_q;
        m_cnt_d   = m_cnt_q;
        m_prev_d  = mode_i;
        short_d   = 1'b0;
        long_d    = 1'b0;
        case (m_state_q)
            M_IDLE: begin
                m_cnt_d = 32'd0;
                if (mode_i && !m_prev_q) begin
                    m_state_d = M_HELD;
                end else begin
                    m_state_d = M_IDLE;
                end
            end
            M_HELD: begin
                if (!mode_i) begin
                    short_d   = 1'b1;
                    m_state_d = M_IDLE;
                    m_cnt_d   = 32'd0;
                end else if (m_cnt_q == LONG_LAST) begin
                    long_d    = 1'b1;
                    m_state_d = M_LONG_DONE;
                    m_cnt_d   = 32'd0;
                end else begin
                    m_cnt_d = m_cnt_q + 32'd1;
                end
            end
            M_LONG_DONE: begin
                m_cnt_d = 32'd0;
                if (!mode_i) begin
                    m_state_d = M_IDLE;
                end else begin
                    m_state_d = M_LONG_DONE;
                end
            end
            default: begin
                m_state_d = M_IDLE;
                m_cnt_d   = 32'd0;
            end
        endcase
    end

    // Mode FSM and registered mode event outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state_q <= M_IDLE;
            m_cnt_q   <= 32'd0;
            m_prev_q  <= 1'b1;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            m_state_q <= m_state_d;
            m_cnt_q   <= m_cnt_d;
            m_prev_q  <= m_prev_d;
            short_q   <= short_d;
            long_q    <= long_d;
        end
    end

    assign mode_short_o = short_q;
    assign mode_long_o  = long_q;

endmodule

// File: tb/tb_button_events.sv
// Directed plus randomized bench for button_events against a press-timeline reference model.
module tb_button_events;

    localparam int L = 20;
    localparam int H = 8;
    localparam int R = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mode_i = 1'b0;
    logic add_i = 1'b0;
    logic sub_i = 1'b0;
    logic mode_short_o, mode_long_o, add_pulse_o, sub_pulse_o;

    button_events #(.LONG_PRESS_CYC(L), .HOLD_DELAY_CYC(H), .REPEAT_CYC(R)) dut (
        .clock        (clock),
        .reset        (reset),
        .mode_i       (mode_i),
        .add_i        (add_i),
        .sub_i        (sub_i),
        .mode_short_o (mode_short_o),
        .mode_long_o  (mode_long_o),
        .add_pulse_o  (add_pulse_o),
        .sub_pulse_o  (sub_pulse_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: each press is a timeline indexed by samples since the press edge.
    bit a_prev, s_prev, m_prev;
    bit a_act, s_act, m_act, m_long_done;
    int a_k, s_k, m_k;
    bit e_add, e_sub, e_short, e_long;
    int n_add, n_sub, n_short, n_long;

    function automatic bit sched(input int k);
        return (k == 0) || (k == H) || (k > H && ((k - H) % R) == 0);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        a_prev = 1'b1; s_prev = 1'b1; m_prev = 1'b1;
        a_act = 1'b0; s_act = 1'b0; m_act = 1'b0; m_long_done = 1'b0;
        a_k = 0; s_k = 0; m_k = 0;
        e_add = 1'b0; e_sub = 1'b0; e_short = 1'b0; e_long = 1'b0;
    endtask

    task automatic key_model(input bit lvl, inout bit prev, inout bit act, inout int k, output bit fire);
        if (lvl && !prev) begin
            act = 1'b1;
            k = 0;
        end else if (lvl && act) begin
            k++;
        end else if (!lvl) begin
            act = 1'b0;
        end
        fire = act && lvl && sched(k);
        prev = lvl;
    endtask

    task automatic model_update(input bit m, input bit a, input bit s);
        bit fa, fs;
        key_model(a, a_prev, a_act, a_k, fa);
        key_model(s, s_prev, s_act, s_k, fs);
        e_add = fa && !(a && s);
        e_sub = fs && !(a && s);
        if (m && !m_prev) begin
            m_act = 1'b1;
            m_k = 0;
            m_long_done = 1'b0;
        end else if (m && m_act) begin
            m_k++;
        end
        e_long  = m_act && m && !m_long_done && (m_k == L);
        if (e_long) m_long_done = 1'b1;
        e_short = m_act && !m && !m_long_done;
        if (!m) m_act = 1'b0;
        m_prev = m;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".add"},   add_pulse_o,  e_add);
        chk({tag, ".sub"},   sub_pulse_o,  e_sub);
        chk({tag, ".short"}, mode_short_o, e_short);
        chk({tag, ".long"},  mode_long_o,  e_long);
    endtask

    task automatic step(input string tag, input bit m, input bit a, input bit s);
        mode_i = m; add_i = a; sub_i = s;
        @(posedge clock);
        #1;
        model_update(m, a, s);
        check_all(tag);
        n_add += int'(add_pulse_o);
        n_sub += int'(sub_pulse_o);
        n_short += int'(mode_short_o);
        n_long += int'(mode_long_o);
    endtask

    task automatic clear_counts();
        n_add = 0; n_sub = 0; n_short = 0; n_long = 0;
    endtask

    initial begin
        int ta, ts, tm;
        bit ra, rs, rm;
        model_reset();
        clear_counts();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        reset = 1'b0;
        repeat (3) step("idle", 1'b0, 1'b0, 1'b0);

        // 1: short add press
        clear_counts();
        repeat (3) step("t1", 1'b0, 1'b1, 1'b0);
        repeat (12) step("t1r", 1'b0, 1'b0, 1'b0);
        chk_int("t1.count", n_add, 1);

        // 2: add held 30 cycles
        clear_counts();
        repeat (30) step("t2", 1'b0, 1'b1, 1'b0);
        repeat (10) step("t2r", 1'b0, 1'b0, 1'b0);
        chk_int("t2.count", n_add, 7);

        // 3: short mode press
        clear_counts();
        repeat (5) step("t3", 1'b1, 1'b0, 1'b0);
        repeat (3) step("t3r", 1'b0, 1'b0, 1'b0);
        chk_int("t3.short", n_short, 1);
        chk_int("t3.long", n_long, 0);

        // 4: long mode press
        clear_counts();
        repeat (40) step("t4", 1'b1, 1'b0, 1'b0);
        repeat (3) step("t4r", 1'b0, 1'b0, 1'b0);
        chk_int("t4.short", n_short, 0);
        chk_int("t4.long", n_long, 1);

        // 5: add/sub conflict, then sub released
        clear_counts();
        repeat (20) step("t5", 1'b0, 1'b1, 1'b1);
        chk_int("t5.conflict", n_add + n_sub, 0);
        repeat (12) step("t5a", 1'b0, 1'b1, 1'b0);
        chk_int("t5.resume", n_add, 3);
        repeat (3) step("t5r", 1'b0, 1'b0, 1'b0);

        // 6a: add held across reset release
        clear_counts();
        add_i = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        reset = 1'b0;
        repeat (12) step("t6a", 1'b0, 1'b1, 1'b0);
        chk_int("t6a.held", n_add, 0);
        step("t6a_rel", 1'b0, 1'b0, 1'b0);
        step("t6a_press", 1'b0, 1'b1, 1'b0);
        chk("t6a.repress", add_pulse_o, 1'b1);
        step("t6a_rel2", 1'b0, 1'b0, 1'b0);

        // 6b: reset asserted while a repeat pulse is on the output
        for (int i = 0; i < 40; i++) begin
            step("t6b", 1'b0, 1'b1, 1'b0);
            if (e_add && a_k > H) break;
        end
        chk("t6b.pre", add_pulse_o, 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6b.async");
        add_i = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clear_counts();
        repeat (6) step("t6b_post", 1'b0, 1'b0, 1'b0);
        chk_int("t6b.trail", n_add, 0);

        // Randomized levels with occasional asynchronous reset
        ta = 1; ts = 1; tm = 1;
        ra = 1'b0; rs = 1'b0; rm = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (--ta == 0) begin ra = !ra; ta = int'($urandom_range(1, 30)); end
            if (--ts == 0) begin rs = !rs; ts = int'($urandom_range(1, 30)); end
            if (--tm == 0) begin rm = !rm; tm = int'($urandom_range(1, 45)); end
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_all("rnd.async");
                @(posedge clock);
                #1;
                reset = 1'b0;
            end
            step("rnd", rm, ra, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
